// File: rtl/sd_sched_pkg.sv
// Shared types and constants for the SD request scheduler.
// Latency: n/a (types, constants and a pure command-word builder).
// Backpressure: n/a.
package sd_sched_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      GRANT = 3'd1,
      ISSUE = 3'd2,
      WAIT  = 3'd3,
      DONE  = 3'd4
   } schedState_t;

   localparam logic [5:0] CMD_RD_DEFAULT = 6'd17;
   localparam logic [5:0] CMD_WR_DEFAULT = 6'd24;

   localparam logic [3:0] STAT_OK      = 4'h0;
   localparam logic [3:0] STAT_TIMEOUT = 4'hF;

   localparam int SEQ_W       = 7;
   localparam int RES_STAT_HI = 35;
   localparam int RES_STAT_LO = 32;

   // Command word layout, MSB first: [71] grant, [70:64] seq, [63:58] cmd,
   // [57:32] reserved zero, [31:0] block address.
   typedef struct packed {
      logic             grantId;
      logic [SEQ_W-1:0] seq;
      logic [5:0]       cmdIdx;
      logic [25:0]      rsvd;
      logic [31:0]      addr;
   } cmdWord_t;

   function automatic cmdWord_t buildCmd(input logic             grantId,
                                         input logic [SEQ_W-1:0] seq,
                                         input logic [5:0]       cmdIdx,
                                         input logic [31:0]      addr);
      cmdWord_t w;
      w.grantId = grantId;
      w.seq     = seq;
      w.cmdIdx  = cmdIdx;
      w.rsvd    = '0;
      w.addr    = addr;
      return w;
   endfunction

endpackage

// File: rtl/sd_rr_arbiter.sv
// Two-way round-robin pick between the APU (0) and DMA/boot (1) requesters.
// Latency: pick is combinational; rrPtr updates on the clock after advance.
// Backpressure: none; the scheduler only samples pick while idle.
// Ports: clk/rst (sync, active-high), reqValid[1:0], advance (request
// finished), doneId (finishing requester) -> anyValid, pick.
module sd_rr_arbiter (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] reqValid,
   input  logic       advance,
   input  logic       doneId,
   output logic       anyValid,
   output logic       pick
);

   logic rrPtr;

   // The requester that just finished drops to lowest priority.
   always_ff @(posedge clk) begin
      if (rst)
         rrPtr <= 1'b0;
      else if (advance)
         rrPtr <= ~doneId;
   end

   always_comb begin
      anyValid = |reqValid;
      pick     = rrPtr;
      if (reqValid == 2'b01)
         pick = 1'b0;
      else if (reqValid == 2'b10)
         pick = 1'b1;
   end

endmodule

// File: rtl/sd_req_scheduler.sv
// Expands multi-block requests from two requesters into single-block CMD17/CMD24 words.
// Latency: reqReady 1 cycle after reqValid seen idle, first cmd strobe 1 cycle later.
// Backpressure: holds in ISSUE while cmdFifoFull; waits in WAIT for a result or timeout.
// Ports: sdClk/sysRst; req{Valid,Ready,Write,Addr,Count} per requester;
// done{Valid,Status,Blocks}; cmdFifo{Data,WrEn,Full}; resultFifo{Data,Empty,RdEn};
// busy, grantId. All outputs are registered.
module sd_req_scheduler
   import sd_sched_pkg::*;
#(
   parameter logic [23:0] TIMEOUT_CYCLES = 24'd2500000,
   parameter logic [5:0]  CMD_RD         = CMD_RD_DEFAULT,
   parameter logic [5:0]  CMD_WR         = CMD_WR_DEFAULT
) (
   input  logic        sdClk,
   input  logic        sysRst,
   input  logic [1:0]  reqValid,
   output logic [1:0]  reqReady,
   input  logic [1:0]  reqWrite,
   input  logic [63:0] reqAddr,
   input  logic [31:0] reqCount,
   output logic [1:0]  doneValid,
   output logic [3:0]  doneStatus,
   output logic [15:0] doneBlocks,
   output logic [71:0] cmdFifoData,
   output logic        cmdFifoWrEn,
   input  logic        cmdFifoFull,
   input  logic [35:0] resultFifoData,
   input  logic        resultFifoEmpty,
   output logic        resultFifoRdEn,
   output logic        busy,
   output logic        grantId
);

   schedState_t      state;
   logic [SEQ_W-1:0] seq;
   logic [23:0]      timer;
   logic [31:0]      curAddr;
   logic [15:0]      curCount;
   logic [15:0]      blkCnt;
   logic             curWrite;

   logic             anyValid;
   logic             pick;

   sd_rr_arbiter u_arb (
      .clk      (sdClk),
      .rst      (sysRst),
      .reqValid (reqValid),
      .advance  (state == DONE),
      .doneId   (grantId),
      .anyValid (anyValid),
      .pick     (pick)
   );

   logic [31:0]      selAddr;
   logic [15:0]      selCount;
   logic             selWrite;
   logic [1:0]       grantMask;
   logic [5:0]       curIdx;
   logic [3:0]       resStatus;
   logic             unusedResp;
   logic [15:0]      blkNext;
   logic [31:0]      addrNext;
   logic [SEQ_W-1:0] seqNext;

   assign selAddr    = grantId ? reqAddr[63:32] : reqAddr[31:0];
   assign selCount   = grantId ? reqCount[31:16] : reqCount[15:0];
   assign selWrite   = reqWrite[grantId];
   assign grantMask  = grantId ? 2'b10 : 2'b01;
   assign curIdx     = curWrite ? CMD_WR : CMD_RD;
   assign resStatus  = resultFifoData[RES_STAT_HI:RES_STAT_LO];
   assign unusedResp = ^resultFifoData[31:0];
   assign blkNext    = blkCnt + 16'd1;
   assign addrNext   = curAddr + 32'd1;
   assign seqNext    = seq + 7'd1;

   // Strobes are registered, so ISSUE/WAIT decide one cycle ahead: the strobe
   // is raised on entry and the state advances on the cycle the strobe is high.
   // Only this block writes the command FIFO, so "not full" sampled a cycle
   // early cannot be invalidated by anyone else.
   always_ff @(posedge sdClk) begin
      if (sysRst) begin
         state          <= IDLE;
         reqReady       <= '0;
         doneValid      <= '0;
         doneStatus     <= STAT_OK;
         doneBlocks     <= '0;
         cmdFifoData    <= '0;
         cmdFifoWrEn    <= 1'b0;
         resultFifoRdEn <= 1'b0;
         busy           <= 1'b0;
         grantId        <= 1'b0;
         seq            <= '0;
         timer          <= '0;
         curAddr        <= '0;
         curCount       <= '0;
         blkCnt         <= '0;
         curWrite       <= 1'b0;
      end else begin
         reqReady       <= '0;
         doneValid      <= '0;
         cmdFifoWrEn    <= 1'b0;
         resultFifoRdEn <= 1'b0;

         case (state)
            IDLE: begin
               if (anyValid) begin
                  grantId  <= pick;
                  reqReady <= pick ? 2'b10 : 2'b01;
                  busy     <= 1'b1;
                  state    <= GRANT;
               end
            end

            GRANT: begin
               curAddr  <= selAddr;
               curCount <= selCount;
               curWrite <= selWrite;
               blkCnt   <= '0;
               if (selCount == 16'd0) begin
                  doneStatus <= STAT_OK;
                  doneBlocks <= '0;
                  doneValid  <= grantMask;
                  state      <= DONE;
               end else begin
                  cmdFifoWrEn <= !cmdFifoFull;
                  cmdFifoData <= buildCmd(grantId, seq, selWrite ? CMD_WR : CMD_RD, selAddr);
                  state       <= ISSUE;
               end
            end

            ISSUE: begin
               if (cmdFifoWrEn) begin
                  timer <= TIMEOUT_CYCLES;
                  state <= WAIT;
               end else begin
                  cmdFifoWrEn <= !cmdFifoFull;
                  cmdFifoData <= buildCmd(grantId, seq, curIdx, curAddr);
               end
            end

            WAIT: begin
               if (resultFifoRdEn) begin
                  // Word is still at the FIFO head during the read strobe.
                  if (resStatus != STAT_OK) begin
                     doneStatus <= resStatus;
                     doneBlocks <= blkCnt;
                     doneValid  <= grantMask;
                     state      <= DONE;
                  end else begin
                     blkCnt  <= blkNext;
                     curAddr <= addrNext;
                     seq     <= seqNext;
                     if (blkNext == curCount) begin
                        doneStatus <= STAT_OK;
                        doneBlocks <= blkNext;
                        doneValid  <= grantMask;
                        state      <= DONE;
                     end else begin
                        cmdFifoWrEn <= !cmdFifoFull;
                        cmdFifoData <= buildCmd(grantId, seqNext, curIdx, addrNext);
                        state       <= ISSUE;
                     end
                  end
               end else if (!resultFifoEmpty) begin
                  // A result seen on the expiring cycle still wins.
                  resultFifoRdEn <= 1'b1;
                  if (timer != 24'd0)
                     timer <= timer - 24'd1;
               end else if (timer <= 24'd1) begin
                  timer      <= '0;
                  doneStatus <= STAT_TIMEOUT;
                  doneBlocks <= blkCnt;
                  doneValid  <= grantMask;
                  state      <= DONE;
               end else begin
                  timer <= timer - 24'd1;
               end
            end

            DONE: begin
               busy  <= 1'b0;
               state <= IDLE;
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_sd_req_scheduler.sv
// Directed bench for sd_req_scheduler with a small result-FIFO responder.
// Latency: n/a.
// Backpressure: cmdFifoFull driven directly by the stimulus.
module tb_sd_req_scheduler;

   logic        sdClk = 1'b0;
   logic        sysRst;
   logic [1:0]  reqValid;
   logic [1:0]  reqReady;
   logic [1:0]  reqWrite;
   logic [63:0] reqAddr;
   logic [31:0] reqCount;
   logic [1:0]  doneValid;
   logic [3:0]  doneStatus;
   logic [15:0] doneBlocks;
   logic [71:0] cmdFifoData;
   logic        cmdFifoWrEn;
   logic        cmdFifoFull;
   logic [35:0] resultFifoData = '0;
   logic        resultFifoEmpty = 1'b1;
   logic        resultFifoRdEn;
   logic        busy;
   logic        grantId;

   int compared   = 0;
   int mismatched = 0;

   logic [71:0] cmdLog[$];
   logic [3:0]  script[$];
   logic [3:0]  resQ[$];
   logic        popPend  = 1'b0;
   logic        pushPend = 1'b0;
   logic [3:0]  pushStat = 4'h0;

   sd_req_scheduler #(.TIMEOUT_CYCLES(24'd16)) dut (
      .sdClk           (sdClk),
      .sysRst          (sysRst),
      .reqValid        (reqValid),
      .reqReady        (reqReady),
      .reqWrite        (reqWrite),
      .reqAddr         (reqAddr),
      .reqCount        (reqCount),
      .doneValid       (doneValid),
      .doneStatus      (doneStatus),
      .doneBlocks      (doneBlocks),
      .cmdFifoData     (cmdFifoData),
      .cmdFifoWrEn     (cmdFifoWrEn),
      .cmdFifoFull     (cmdFifoFull),
      .resultFifoData  (resultFifoData),
      .resultFifoEmpty (resultFifoEmpty),
      .resultFifoRdEn  (resultFifoRdEn),
      .busy            (busy),
      .grantId         (grantId)
   );

   always #5 sdClk = ~sdClk;

   // Responder: each logged command queues the next scripted status as a
   // result word. Pushes and pops take effect at the posedge after they are
   // observed, so they are applied at the following negedge.
   always @(negedge sdClk) begin
      if (sysRst) begin
         resQ.delete();
         popPend  = 1'b0;
         pushPend = 1'b0;
      end else begin
         if (popPend && resQ.size() > 0)
            void'(resQ.pop_front());
         if (pushPend)
            resQ.push_back(pushStat);
         popPend  = resultFifoRdEn;
         pushPend = 1'b0;
         if (cmdFifoWrEn) begin
            cmdLog.push_back(cmdFifoData);
            if (script.size() > 0) begin
               pushPend = 1'b1;
               pushStat = script.pop_front();
            end
         end
      end
      resultFifoEmpty = (resQ.size() == 0);
      resultFifoData  = (resQ.size() > 0) ? {resQ[0], 32'hABCD0000} : 36'd0;
   end

   task automatic tick();
      @(posedge sdClk);
      #1;
   endtask

   task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] exp);
      compared++;
      assert (obs === exp)
      else begin
         mismatched++;
         $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [71:0] expWord(input logic g, input int seq, input logic wr,
                                           input logic [31:0] a);
      logic [6:0] s;
      s = seq[6:0];
      return {g, s, (wr ? 6'd24 : 6'd17), 26'd0, a};
   endfunction

   // Presents a request, checks the accept pulse, and withdraws it after the
   // capture edge. Returns just after the GRANT-state edge.
   task automatic issueReq(input int port, input logic wr, input logic [31:0] a,
                           input logic [15:0] cnt, input string tag);
      if (port == 1) begin
         reqAddr[63:32]  = a;
         reqCount[31:16] = cnt;
      end else begin
         reqAddr[31:0]  = a;
         reqCount[15:0] = cnt;
      end
      reqWrite[port] = wr;
      reqValid[port] = 1'b1;
      tick();
      check({tag, "_ready"}, 72'(reqReady), 72'((port == 1) ? 2'b10 : 2'b01));
      tick();
      reqValid = 2'b00;
   endtask

   task automatic waitReady(output logic [1:0] obs);
      int n;
      n = 0;
      do begin
         tick();
         n++;
      end while (reqReady == 2'b00 && n < 200);
      obs = reqReady;
   endtask

   task automatic waitDone(input int port, input logic [3:0] st, input logic [15:0] blk,
                           input string tag);
      int n;
      n = 0;
      do begin
         tick();
         n++;
      end while (doneValid == 2'b00 && n < 200);
      check({tag, "_doneValid"}, 72'(doneValid), 72'((port == 1) ? 2'b10 : 2'b01));
      check({tag, "_status"}, 72'(doneStatus), 72'(st));
      check({tag, "_blocks"}, 72'(doneBlocks), 72'(blk));
   endtask

   initial begin
      logic [1:0] obs;
      int         expSeq;
      int         n;
      int         pulses;

      sysRst      = 1'b1;
      reqValid    = 2'b00;
      reqWrite    = 2'b00;
      reqAddr     = '0;
      reqCount    = '0;
      cmdFifoFull = 1'b0;
      tick();
      tick();
      tick();
      check("rst_reqReady", 72'(reqReady), 72'(0));
      check("rst_cmdWrEn", 72'(cmdFifoWrEn), 72'(0));
      check("rst_busy", 72'(busy), 72'(0));
      check("rst_doneValid", 72'(doneValid), 72'(0));
      check("rst_rdEn", 72'(resultFifoRdEn), 72'(0));
      check("rst_cmdData", cmdFifoData, 72'(0));
      sysRst = 1'b0;
      tick();

      // Port 0 three-block read.
      expSeq = 0;
      cmdLog.delete();
      script = '{4'h0, 4'h0, 4'h0};
      issueReq(0, 1'b0, 32'h100, 16'd3, "rd3");
      check("rd3_firstStrobe", 72'(cmdFifoWrEn), 72'(1));
      check("rd3_busy", 72'(busy), 72'(1));
      waitDone(0, 4'h0, 16'd3, "rd3");
      check("rd3_nWords", 72'(cmdLog.size()), 72'(3));
      for (int i = 0; i < 3; i++)
         if (cmdLog.size() > i)
            check($sformatf("rd3_word%0d", i), cmdLog[i], expWord(1'b0, expSeq + i, 1'b0, 32'h100 + i));
      tick();
      tick();
      check("rd3_idle", 72'(busy), 72'(0));

      // Both valid at reset release: strict alternation 0,1,0.
      sysRst   = 1'b1;
      cmdLog.delete();
      script   = '{4'h0, 4'h0, 4'h0};
      reqValid = 2'b11;
      reqWrite = 2'b01;
      reqAddr  = {32'h200, 32'h300};
      reqCount = {16'd1, 16'd1};
      tick();
      tick();
      sysRst = 1'b0;
      expSeq = 0;
      waitReady(obs);
      check("alt_grant0", 72'(obs), 72'(2'b01));
      waitReady(obs);
      check("alt_grant1", 72'(obs), 72'(2'b10));
      check("alt_grantId1", 72'(grantId), 72'(1));
      waitReady(obs);
      check("alt_grant2", 72'(obs), 72'(2'b01));
      tick();
      reqValid = 2'b00;
      waitDone(0, 4'h0, 16'd1, "alt");
      check("alt_nWords", 72'(cmdLog.size()), 72'(3));
      if (cmdLog.size() == 3) begin
         check("alt_word0", cmdLog[0], expWord(1'b0, 0, 1'b1, 32'h300));
         check("alt_word1", cmdLog[1], expWord(1'b1, 1, 1'b0, 32'h200));
         check("alt_word2", cmdLog[2], expWord(1'b0, 2, 1'b1, 32'h300));
      end
      expSeq = 3;
      tick();
      tick();

      // Port 1 write across the address wrap with the command FIFO full.
      cmdLog.delete();
      script      = '{4'h0, 4'h0};
      cmdFifoFull = 1'b1;
      issueReq(1, 1'b1, 32'hFFFF_FFFF, 16'd2, "wrap");
      for (int i = 0; i < 5; i++) begin
         check($sformatf("wrap_noStrobe%0d", i), 72'(cmdFifoWrEn), 72'(0));
         if (i < 4)
            tick();
      end
      cmdFifoFull = 1'b0;
      tick();
      check("wrap_strobe", 72'(cmdFifoWrEn), 72'(1));
      waitDone(1, 4'h0, 16'd2, "wrap");
      check("wrap_nWords", 72'(cmdLog.size()), 72'(2));
      if (cmdLog.size() == 2) begin
         check("wrap_word0", cmdLog[0], expWord(1'b1, expSeq, 1'b1, 32'hFFFF_FFFF));
         check("wrap_word1", cmdLog[1], expWord(1'b1, expSeq + 1, 1'b1, 32'h0000_0000));
      end
      expSeq += 2;
      tick();
      tick();

      // Error status on the second block abandons the rest.
      cmdLog.delete();
      script = '{4'h0, 4'h3};
      issueReq(0, 1'b0, 32'h40, 16'd4, "err");
      waitDone(0, 4'h3, 16'd1, "err");
      tick();
      tick();
      tick();
      check("err_nWords", 72'(cmdLog.size()), 72'(2));
      if (cmdLog.size() == 2)
         check("err_word1", cmdLog[1], expWord(1'b0, expSeq + 1, 1'b0, 32'h41));
      check("err_idle", 72'(busy), 72'(0));
      expSeq += 1;

      // No result word: timeout 16 cycles after WAIT is entered.
      cmdLog.delete();
      script.delete();
      issueReq(1, 1'b0, 32'h55, 16'd1, "tmo");
      check("tmo_strobe", 72'(cmdFifoWrEn), 72'(1));
      check("tmo_word", cmdFifoData, expWord(1'b1, expSeq, 1'b0, 32'h55));
      n = 0;
      do begin
         tick();
         n++;
      end while (doneValid == 2'b00 && n < 100);
      check("tmo_cycles", 72'(n), 72'(17));
      check("tmo_doneValid", 72'(doneValid), 72'(2'b10));
      check("tmo_status", 72'(doneStatus), 72'(4'hF));
      check("tmo_blocks", 72'(doneBlocks), 72'(0));
      tick();
      tick();

      // Zero-count request completes without touching the command FIFO.
      cmdLog.delete();
      issueReq(0, 1'b0, 32'h99, 16'd0, "zero");
      check("zero_doneValid", 72'(doneValid), 72'(2'b01));
      check("zero_status", 72'(doneStatus), 72'(0));
      check("zero_blocks", 72'(doneBlocks), 72'(0));
      check("zero_noStrobe", 72'(cmdFifoWrEn), 72'(0));
      tick();
      check("zero_idle", 72'(busy), 72'(0));
      check("zero_nWords", 72'(cmdLog.size()), 72'(0));
      tick();

      // Reset while waiting for a result.
      script.delete();
      issueReq(1, 1'b0, 32'h77, 16'd2, "rst");
      tick();
      tick();
      check("rst_midBusy", 72'(busy), 72'(1));
      check("rst_midGrant", 72'(grantId), 72'(1));
      sysRst = 1'b1;
      tick();
      check("rstw_busy", 72'(busy), 72'(0));
      check("rstw_grantId", 72'(grantId), 72'(0));
      check("rstw_cmdData", cmdFifoData, 72'(0));
      check("rstw_cmdWrEn", 72'(cmdFifoWrEn), 72'(0));
      check("rstw_rdEn", 72'(resultFifoRdEn), 72'(0));
      check("rstw_doneValid", 72'(doneValid), 72'(0));
      check("rstw_reqReady", 72'(reqReady), 72'(0));
      check("rstw_doneBlocks", 72'(doneBlocks), 72'(0));
      sysRst = 1'b0;
      pulses = 0;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (doneValid != 2'b00)
            pulses++;
      end
      check("rstw_noDone", 72'(pulses), 72'(0));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/sd_req_scheduler.md
# sd_req_scheduler

Arbitrates block-transfer requests from two requesters (port 0: APU command path, port 1: DMA/boot engine) onto the single SD card datapath. It expands each multi-block request into single-block CMD17/CMD24 command words in the command FIFO, consumes the matching result words, and reports per-request completion. It sits between the requesters and the cmd/result FIFOs on the sdEngine side, in the SD clock domain.

## Interface
- TIMEOUT_CYCLES, 24'd2500000, sdClk cycles to wait for a result word before aborting (100 ms at 25 MHz).
- CMD_RD, 6'd17, command index used for single-block reads.
- CMD_WR, 6'd24, command index used for single-block writes.

- sdClk  in  1  SD-domain clock; the only clock.
- sysRst  in  1  reset, synchronous, active-high.
- reqValid  in  2  per-requester request valid; held until reqReady.
- reqReady  out  2  one-cycle accept pulse; fields captured that cycle.
- reqWrite  in  2  1 = write, 0 = read, per requester.
- reqAddr  in  64  {addr1, addr0}; 32-bit block address each.
- reqCount  in  32  {cnt1, cnt0}; 16-bit block count each.
- doneValid  out  2  one-cycle completion pulse to the owning requester.
- doneStatus  out  4  0 = OK, result status on error, 4'hF = timeout.
- doneBlocks  out  16  blocks completed successfully.
- cmdFifoData  out  72  command word.
- cmdFifoWrEn  out  1  command FIFO write strobe.
- cmdFifoFull  in  1  command FIFO full.
- resultFifoData  in  36  result word (first-word-fall-through).
- resultFifoEmpty  in  1  result FIFO empty.
- resultFifoRdEn  out  1  result FIFO read strobe.
- busy  out  1  high in any state except IDLE.
- grantId  out  1  requester currently owning the datapath.

## Operation
- Command word: [71] grantId, [70:64] 7-bit sequence number, [63:58] CMD_RD/CMD_WR, [57:32] zero, [31:0] block address.
- Result word: [35:32] status, [31:0] card response (ignored here).
- States: IDLE, GRANT, ISSUE, WAIT, DONE.
- IDLE: if any reqValid, pick the requester. With both valid, pick rrPtr. With one valid, pick that one. Go to GRANT.
- GRANT: reqReady[g]=1. Capture addr, count and write; clear blkCnt. If count==0, go to DONE with status 0. Otherwise go to ISSUE.
- ISSUE: when !cmdFifoFull, cmdFifoWrEn=1 for one cycle with the current word. Load the timeout counter with TIMEOUT_CYCLES and go to WAIT. While cmdFifoFull, stay in ISSUE with no strobe.
- WAIT: when !resultFifoEmpty, resultFifoRdEn=1 for one cycle.
  - If status≠0, latch the status and go to DONE; remaining blocks are abandoned.
  - Otherwise blkCnt+1, address+1 (modulo 2^32; wraps 0xFFFFFFFF→0), and sequence+1 (modulo 128). Go to DONE if blkCnt+1==count, else to ISSUE.
  - If the counter reaches 0 first, status=4'hF and go to DONE.
  - A result arriving on the same cycle the counter expires wins.
- DONE: doneValid[g]=1 with doneStatus and doneBlocks=blkCnt. Set rrPtr=~g and go to IDLE.
- Grant is held for the whole request; no preemption.
- reqValid dropped before reqReady is undefined requester behaviour; the scheduler does not check for it.

## Timing
- Reset values: all outputs 0, state IDLE, rrPtr 0, sequence 0, timeout counter 0.
- sysRst mid-transfer aborts immediately with no doneValid. The FIFOs share sysRst, so in-flight words are flushed.
- Minimum latency: reqValid seen in IDLE at cycle n; reqReady at n+1; cmdFifoWrEn at n+2 if not full.
- Each result is consumed the cycle after it is seen non-empty in WAIT.
- doneValid is asserted one cycle after the final result read. The scheduler is back in IDLE the cycle after that.
- With both requesters continuously valid, grants alternate strictly.
- All outputs are registered.

## Structure
- Package sd_sched_pkg holds:
  - state enum;
  - CMD_RD/CMD_WR defaults;
  - status codes: STAT_OK=0, STAT_TIMEOUT=4'hF;
  - command/result field bit positions;
  - a function building the 72-bit command word.
- One sub-module, sd_rr_arbiter: a 2-way round-robin pick from reqValid and rrPtr, combinational plus an rrPtr register updated on DONE.

## Test plan
- Port 0: read, addr 0x100, count 3, results all status 0 → three words with cmd 17 at addrs 0x100/0x101/0x102 and sequence 0/1/2; doneValid[0], status 0, blocks 3.
- Both ports valid at reset release (port 0 write count 1, port 1 read count 1) → port 0 granted first (rrPtr 0); then port 1; then port 0 again if it is re-requested.
- Port 1: write, addr 0xFFFFFFFF, count 2; cmdFifoFull held for 5 cycles → no strobe while full; second word at addr 0x00000000; doneBlocks 2.
- Second result has status 4'h3, count 4 → exactly two command words; doneStatus 3, doneBlocks 1.
- No result word, TIMEOUT_CYCLES=16 → doneStatus 4'hF exactly 16 cycles after entering WAIT; doneBlocks 0.
- count 0 → no cmdFifoWrEn; doneValid one cycle after reqReady. sysRst asserted in WAIT → all outputs 0 the next cycle, no doneValid.
